// File: rtl/trap_pkg.sv
// trap_pkg: shared cause codes, FSM encoding, pc_sel encodings and mstatus bit indices
package trap_pkg;

    localparam logic [3:0] EXC_IF_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_EBREAK      = 4'd3;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ECALL       = 4'd11;
    localparam logic [3:0] IRQ_MSI         = 4'd3;
    localparam logic [3:0] IRQ_MTI         = 4'd7;
    localparam logic [3:0] IRQ_MEI         = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] PC_SEL_NORMAL = 2'b00;
    localparam logic [1:0] PC_SEL_TRAP   = 2'b01;
    localparam logic [1:0] PC_SEL_MEPC   = 2'b10;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: pipeline/CSR-side signals of the trap sequencer; slave = trap_ctrl, master = its driver
interface trap_ctrl_if;
    logic        instr_valid_in;
    logic [31:0] pc_in;
    logic [5:0]  exc_req_in;
    logic [2:0]  irq_pend_in;
    logic [2:0]  irq_en_in;
    logic        mret_in;
    logic        csr_wr_en_in;
    logic [11:0] csr_addr_in;
    logic [31:0] data_wr_in;
    logic        int_or_exc_out;
    logic [3:0]  cause_out;
    logic        mepc_wr_en_out;
    logic [31:0] mepc_out;
    logic        mcause_wr_en_out;
    logic [1:0]  pc_sel_out;
    logic        flush_out;
    logic        stall_out;
    logic        mstatus_mie_out;
    logic        mstatus_mpie_out;

    modport master (
        output instr_valid_in, pc_in, exc_req_in, irq_pend_in, irq_en_in, mret_in,
               csr_wr_en_in, csr_addr_in, data_wr_in,
        input  int_or_exc_out, cause_out, mepc_wr_en_out, mepc_out, mcause_wr_en_out,
               pc_sel_out, flush_out, stall_out, mstatus_mie_out, mstatus_mpie_out
    );

    modport slave (
        input  instr_valid_in, pc_in, exc_req_in, irq_pend_in, irq_en_in, mret_in,
               csr_wr_en_in, csr_addr_in, data_wr_in,
        output int_or_exc_out, cause_out, mepc_wr_en_out, mepc_out, mcause_wr_en_out,
               pc_sel_out, flush_out, stall_out, mstatus_mie_out, mstatus_mpie_out
    );
endinterface

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: picks the winning trap; exceptions beat interrupts, interrupts gated by MIE
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [5:0] exc_req_i,
    input  logic [2:0] irq_i,
    input  logic       mie_i,
    output logic       take_o,
    output logic       int_or_exc_o,
    output logic [3:0] cause_o
);

    logic exc_any;
    logic irq_any;

    // fixed-priority selection; exc_req bits are {st, ld, ecall, ebreak, illegal, if}
    always_comb begin
        exc_any      = |exc_req_i;
        irq_any      = mie_i & (|irq_i);
        take_o       = exc_any | irq_any;
        int_or_exc_o = ~exc_any & irq_any;
        cause_o      = exc_req_i[0] ? EXC_IF_MISALIGN :
                       exc_req_i[1] ? EXC_ILLEGAL     :
                       exc_req_i[2] ? EXC_EBREAK      :
                       exc_req_i[3] ? EXC_ECALL       :
                       exc_req_i[4] ? EXC_LD_MISALIGN :
                       exc_req_i[5] ? EXC_ST_MISALIGN :
                       irq_i[2]     ? IRQ_MEI         :
                       irq_i[0]     ? IRQ_MSI         :
                       irq_i[1]     ? IRQ_MTI         : 4'd0;
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret sequencer owning mstatus MIE/MPIE
// Optional: define TRAP_COUNT_EN to add trap_cnt_out, a saturating count of trap entries.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [11:0] MSTATUS    = 12'h300,
    parameter logic        MIE_RESET  = 1'b0,
    parameter logic        MPIE_RESET = 1'b0
) (
    input  logic        clock,
    input  logic        rst_n_in,
    trap_ctrl_if.slave  bus
`ifdef TRAP_COUNT_EN
    ,
    output logic [31:0] trap_cnt_out
`endif
);

    state_e      state_q;
    logic        mie_q;
    logic        mpie_q;
    logic        int_or_exc_q;
    logic [3:0]  cause_q;
    logic [31:0] mepc_q;
    logic        trap_wr_q;
    logic [1:0]  pc_sel_q;
    logic        busy_q;
    logic        take;
    logic        int_or_exc_d;
    logic [3:0]  cause_d;
    logic        trap_go;
    logic        csr_hit;
`ifdef TRAP_COUNT_EN
    logic [31:0] trap_cnt_q;
`endif

    trap_prio_enc u_prio (
        .exc_req_i    (bus.exc_req_in),
        .irq_i        (bus.irq_pend_in & bus.irq_en_in),
        .mie_i        (mie_q),
        .take_o       (take),
        .int_or_exc_o (int_or_exc_d),
        .cause_o      (cause_d)
    );

    // trap decisions are only made at an instruction boundary in IDLE
    always_comb begin
        trap_go = (state_q == ST_IDLE) & bus.instr_valid_in & take;
        csr_hit = (state_q == ST_IDLE) & bus.csr_wr_en_in & (bus.csr_addr_in == MSTATUS) & ~trap_go;
    end

    // sequencer FSM with registered strobes; a coincident trap overrides an mstatus write
    always_ff @(posedge clock or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            mie_q        <= MIE_RESET;
            mpie_q       <= MPIE_RESET;
            int_or_exc_q <= 1'b0;
            cause_q      <= 4'd0;
            mepc_q       <= 32'd0;
            trap_wr_q    <= 1'b0;
            pc_sel_q     <= PC_SEL_NORMAL;
            busy_q       <= 1'b0;
        end else begin
            if (csr_hit) begin
                mie_q  <= bus.data_wr_in[MSTATUS_MIE_BIT];
                mpie_q <= bus.data_wr_in[MSTATUS_MPIE_BIT];
            end
            case (state_q)
                ST_IDLE: begin
                    if (trap_go) begin
                        state_q      <= ST_TRAP;
                        int_or_exc_q <= int_or_exc_d;
                        cause_q      <= cause_d;
                        mepc_q       <= bus.pc_in;
                        trap_wr_q    <= 1'b1;
                        pc_sel_q     <= PC_SEL_TRAP;
                        busy_q       <= 1'b1;
                    end else if (bus.instr_valid_in && bus.mret_in) begin
                        state_q  <= ST_RET;
                        pc_sel_q <= PC_SEL_MEPC;
                        busy_q   <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    state_q   <= ST_DRAIN;
                    trap_wr_q <= 1'b0;
                    pc_sel_q  <= PC_SEL_NORMAL;
                    mpie_q    <= mie_q;
                    mie_q     <= 1'b0;
                end
                ST_RET: begin
                    state_q  <= ST_DRAIN;
                    pc_sel_q <= PC_SEL_NORMAL;
                    mie_q    <= mpie_q;
                    mpie_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRAP_COUNT_EN
    // saturating count of IDLE->TRAP transitions
    always_ff @(posedge clock or negedge rst_n_in) begin
        if (!rst_n_in)
            trap_cnt_q <= 32'd0;
        else if (trap_go && trap_cnt_q != 32'hFFFF_FFFF)
            trap_cnt_q <= trap_cnt_q + 32'd1;
    end

    assign trap_cnt_out = trap_cnt_q;
`endif

    assign bus.int_or_exc_out   = int_or_exc_q;
    assign bus.cause_out        = cause_q;
    assign bus.mepc_wr_en_out   = trap_wr_q;
    assign bus.mcause_wr_en_out = trap_wr_q;
    assign bus.mepc_out         = mepc_q;
    assign bus.pc_sel_out       = pc_sel_q;
    assign bus.flush_out        = busy_q;
    assign bus.stall_out        = busy_q;
    assign bus.mstatus_mie_out  = mie_q;
    assign bus.mstatus_mpie_out = mpie_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl; expected trap/mret records are queued at drive time
module tb_trap_ctrl;

    typedef struct {
        bit        ret;
        bit        intr;
        bit [3:0]  cause;
        bit [31:0] pc;
    } exp_t;

    typedef struct {
        bit [5:0] exc;
        bit [2:0] pend;
        bit [2:0] en;
        bit       intr;
        bit [3:0] cause;
    } prio_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_wr = 0;
    exp_t sbq[$];
    exp_t e;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clock    (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
`ifdef TRAP_COUNT_EN
        ,
        .trap_cnt_out (trap_cnt)
`endif
    );

`ifdef TRAP_COUNT_EN
    logic [31:0] trap_cnt;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.instr_valid_in = 1'b0;
        bus.exc_req_in     = 6'd0;
        bus.irq_pend_in    = 3'd0;
        bus.mret_in        = 1'b0;
        bus.csr_wr_en_in   = 1'b0;
    endtask

    task automatic csr_write(input logic [31:0] d);
        bus.csr_wr_en_in = 1'b1;
        bus.csr_addr_in  = 12'h300;
        bus.data_wr_in   = d;
        step();
        bus.csr_wr_en_in = 1'b0;
    endtask

    task automatic do_trap(input logic [5:0] exc, input logic [2:0] pend, input logic [2:0] en,
                           input logic mret, input logic [31:0] pc, input logic intr, input logic [3:0] cause);
        bus.instr_valid_in = 1'b1;
        bus.exc_req_in     = exc;
        bus.irq_pend_in    = pend;
        bus.irq_en_in      = en;
        bus.mret_in        = mret;
        bus.pc_in          = pc;
        sbq.push_back('{ret: 1'b0, intr: intr, cause: cause, pc: pc});
        step();
        clear_in();
        chk("trap_pc_sel", bus.pc_sel_out, 2'b01);
        chk("trap_flush", bus.flush_out, 1'b1);
        chk("trap_stall", bus.stall_out, 1'b1);
        step();
        chk("drain_pc_sel", bus.pc_sel_out, 2'b00);
        chk("drain_stall", bus.stall_out, 1'b1);
        chk("drain_mepc_wr", bus.mepc_wr_en_out, 1'b0);
        step();
        chk("idle_stall", bus.stall_out, 1'b0);
    endtask

    // scoreboard: every mcause write or mepc redirect must match the oldest queued record
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mepc_wr_en_out) n_wr++;
            chk("wr_pair", bus.mcause_wr_en_out, bus.mepc_wr_en_out);
            if (bus.mcause_wr_en_out || bus.pc_sel_out == 2'b10) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected", bus.pc_sel_out, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_kind", bus.pc_sel_out, e.ret ? 2'b10 : 2'b01);
                    if (!e.ret) begin
                        chk("sb_cause", bus.cause_out, e.cause);
                        chk("sb_int", bus.int_or_exc_out, e.intr);
                        chk("sb_mepc", bus.mepc_out, e.pc);
                    end
                end
            end
        end
    end

    prio_t tbl[10] = '{
        '{6'b000101, 3'b000, 3'b111, 1'b0, 4'd0},
        '{6'b110000, 3'b000, 3'b111, 1'b0, 4'd4},
        '{6'b100000, 3'b000, 3'b111, 1'b0, 4'd6},
        '{6'b101000, 3'b000, 3'b111, 1'b0, 4'd11},
        '{6'b001100, 3'b000, 3'b111, 1'b0, 4'd3},
        '{6'b000000, 3'b011, 3'b111, 1'b1, 4'd3},
        '{6'b000000, 3'b010, 3'b111, 1'b1, 4'd7},
        '{6'b000000, 3'b111, 3'b011, 1'b1, 4'd3},
        '{6'b000000, 3'b100, 3'b100, 1'b1, 4'd11},
        '{6'b100000, 3'b111, 3'b111, 1'b0, 4'd6}
    };

    initial begin
        int wr_before;
        clear_in();
        bus.irq_en_in   = 3'd0;
        bus.pc_in       = 32'd0;
        bus.csr_addr_in = 12'd0;
        bus.data_wr_in  = 32'd0;
        #12;
        chk("rst_pc_sel", bus.pc_sel_out, 2'b00);
        chk("rst_stall", bus.stall_out, 1'b0);
        chk("rst_flush", bus.flush_out, 1'b0);
        chk("rst_mepc_wr", bus.mepc_wr_en_out, 1'b0);
        chk("rst_mepc", bus.mepc_out, 32'd0);
        chk("rst_cause", bus.cause_out, 4'd0);
        chk("rst_int", bus.int_or_exc_out, 1'b0);
        chk("rst_mie", bus.mstatus_mie_out, 1'b0);
        chk("rst_mpie", bus.mstatus_mpie_out, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        csr_write(32'h8);
        chk("csr_mie_set", bus.mstatus_mie_out, 1'b1);
        chk("csr_mpie_clr", bus.mstatus_mpie_out, 1'b0);
        do_trap(6'b001010, 3'b000, 3'b000, 1'b0, 32'h100, 1'b0, 4'd2);
        chk("trap_mie", bus.mstatus_mie_out, 1'b0);
        chk("trap_mpie", bus.mstatus_mpie_out, 1'b1);
        bus.instr_valid_in = 1'b1;
        bus.mret_in = 1'b1;
        sbq.push_back('{ret: 1'b1, intr: 1'b0, cause: 4'd0, pc: 32'd0});
        step();
        clear_in();
        chk("ret_pc_sel", bus.pc_sel_out, 2'b10);
        chk("ret_stall", bus.stall_out, 1'b1);
        step();
        chk("ret_drain_pc_sel", bus.pc_sel_out, 2'b00);
        chk("ret_mie", bus.mstatus_mie_out, 1'b1);
        chk("ret_mpie", bus.mstatus_mpie_out, 1'b1);
        step();
        do_trap(6'b000000, 3'b111, 3'b111, 1'b0, 32'h200, 1'b1, 4'd11);
        chk("irq_mie", bus.mstatus_mie_out, 1'b0);
        bus.instr_valid_in = 1'b1;
        bus.irq_pend_in = 3'b111;
        step();
        clear_in();
        chk("masked_stall", bus.stall_out, 1'b0);
        chk("masked_wr", bus.mcause_wr_en_out, 1'b0);
        do_trap(6'b000100, 3'b000, 3'b111, 1'b1, 32'h240, 1'b0, 4'd3);
        bus.instr_valid_in = 1'b1;
        bus.exc_req_in = 6'b000001;
        bus.pc_in = 32'h300;
        sbq.push_back('{ret: 1'b0, intr: 1'b0, cause: 4'd0, pc: 32'h300});
        step();
        clear_in();
        step();
        chk("drain_state", bus.stall_out, 1'b1);
        csr_write(32'h8);
        chk("drain_csr_ignored", bus.mstatus_mie_out, 1'b0);
        csr_write(32'h8);
        chk("idle_csr_mie", bus.mstatus_mie_out, 1'b1);
        foreach (tbl[i]) begin
            csr_write(32'h8);
            do_trap(tbl[i].exc, tbl[i].pend, tbl[i].en, 1'b0, 32'h1000 + 32'(i) * 4,
                    tbl[i].intr, tbl[i].cause);
        end
        bus.exc_req_in = 6'b000010;
        step();
        clear_in();
        chk("novalid_stall", bus.stall_out, 1'b0);
        bus.instr_valid_in = 1'b1;
        bus.exc_req_in = 6'b000001;
        bus.pc_in = 32'h500;
        step();
        clear_in();
        chk("pre_rst_wr", bus.mepc_wr_en_out, 1'b1);
        wr_before = n_wr;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr", bus.mepc_wr_en_out, 1'b0);
        chk("midrst_pc_sel", bus.pc_sel_out, 2'b00);
        chk("midrst_stall", bus.stall_out, 1'b0);
        chk("midrst_mepc", bus.mepc_out, 32'd0);
        chk("midrst_mie", bus.mstatus_mie_out, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst_no_wr", n_wr, wr_before);
        chk("post_rst_pc_sel", bus.pc_sel_out, 2'b00);
`ifdef TRAP_COUNT_EN
        chk("cnt_rst", trap_cnt, 32'd0);
        for (int k = 0; k < 3; k++)
            do_trap(6'b000010, 3'b000, 3'b000, 1'b0, 32'h600 + 32'(k), 1'b0, 4'd2);
        chk("cnt_three", trap_cnt, 32'd3);
`endif
        step();
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer for the RISC_V core. It sits between the pipeline and the mtvec/CSR block.
- Arbitrates pending exceptions and interrupts and produces the `int_or_exc` and 4-bit cause values that select the trap vector.
- Sequences trap entry and `mret`: mepc/mcause writes, pipeline flush, PC redirect.
- Owns the mstatus MIE/MPIE bits.

Parameters:
- `MSTATUS`, 12'h300, CSR address decoded for MIE (bit 3) / MPIE (bit 7) writes.
- `MIE_RESET`, 1'b0, reset value of mstatus.MIE.
- `MPIE_RESET`, 1'b0, reset value of mstatus.MPIE.

Ports:
- `clock`  in  1  core clock
- `rst_n_in`  in  1  asynchronous active-low reset
- `instr_valid_in`  in  1  instruction in commit stage is valid (boundary for trap check)
- `pc_in`  in  32  PC of commit-stage instruction
- `exc_req_in`  in  6  {st_misalign, ld_misalign, ecall, ebreak, illegal, if_misalign}
- `irq_pend_in`  in  3  {meip, mtip, msip}
- `irq_en_in`  in  3  mie register bits {meie, mtie, msie}
- `mret_in`  in  1  commit-stage instruction is mret
- `csr_wr_en_in`  in  1  CSR write strobe
- `csr_addr_in`  in  12  CSR address
- `data_wr_in`  in  32  CSR write data
- `int_or_exc_out`  out  1  1 = interrupt, 0 = exception (to trap-vector block)
- `cause_out`  out  4  cause code (to trap-vector block and mcause)
- `mepc_wr_en_out`  out  1  write `mepc_out` into mepc
- `mepc_out`  out  32  PC to save
- `mcause_wr_en_out`  out  1  write {`int_or_exc_out`, 27'b0, `cause_out`} into mcause
- `pc_sel_out`  out  2  00 normal, 01 trap vector, 10 mepc (mret)
- `flush_out`  out  1  flush fetch/decode
- `stall_out`  out  1  hold commit stage
- `mstatus_mie_out`  out  1  current MIE
- `mstatus_mpie_out`  out  1  current MPIE

Behaviour:
- Reset (`rst_n_in` low, async): state=IDLE; MIE=`MIE_RESET`, MPIE=`MPIE_RESET`; all strobes, `pc_sel_out`, `flush_out`, `stall_out`, `int_or_exc_out` and `cause_out` are 0; `mepc_out`=0. Reset mid-sequence aborts to IDLE with no CSR write.
- Trap condition, evaluated in IDLE only when `instr_valid_in`=1:
  - Exception pending if `|exc_req_in`.
  - Interrupt pending if MIE & `|(irq_pend_in & irq_en_in)`.
- Priority, exceptions over interrupts:
  - Exceptions: if_misalign(0) > illegal(2) > ebreak(3) > ecall(11) > ld_misalign(4) > st_misalign(6).
  - Interrupts: MEI(11) > MSI(3) > MTI(7).
- Trap over mret: if `mret_in` and a trap are both pending, the trap wins and mret is ignored.
- FSM states: IDLE, TRAP, RET, DRAIN.
- IDLE→TRAP on a trap condition. The cause and `int_or_exc` are registered, and `mepc_out`=`pc_in` is registered. TRAP is held for exactly 1 cycle, during which:
  - `mepc_wr_en_out`=1, `mcause_wr_en_out`=1, `pc_sel_out`=01, `flush_out`=1, `stall_out`=1.
  - MPIE<=MIE and MIE<=0 on exit.
- IDLE→RET on `mret_in`&`instr_valid_in` with no trap. RET is held for 1 cycle, during which:
  - `pc_sel_out`=10, `flush_out`=1, `stall_out`=1.
  - MIE<=MPIE and MPIE<=1 on exit.
- TRAP/RET→DRAIN: 1 cycle with `flush_out`=1, `stall_out`=1, `pc_sel_out`=00. Then →IDLE.
- Latency: trap detect to vector fetch is 1 cycle. Minimum spacing between back-to-back traps is 3 cycles.
- CSR write to `MSTATUS`:
  - Accepted only in IDLE; it updates MIE/MPIE from `data_wr_in`[3]/[7].
  - If it coincides with a trap decision, the trap uses the old MIE and the FSM bit update wins.
  - Writes in TRAP/RET/DRAIN are ignored.
- `cause_out` and `int_or_exc_out` hold their last value outside TRAP. They are meaningful only while `mcause_wr_en_out`=1.
- `irq_pend_in` is level-sensitive and is not latched. An interrupt that deasserts before IDLE sampling is lost.

Optional Feature:
- `TRAP_COUNT_EN`: adds output `trap_cnt_out[31:0]`, a saturating count of TRAP-state entries.
  - Resets to 0.
  - Increments on IDLE→TRAP.
  - Holds at 32'hFFFF_FFFF.
- Without the macro the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Package `trap_pkg` holds:
  - Cause code localparams (EXC_IF_MISALIGN=0 … IRQ_MEI=11).
  - FSM state encoding (2-bit).
  - `pc_sel` encodings.
  - `MSTATUS` bit indices.
- Sub-module `trap_prio_enc`: combinational priority encoder taking `exc_req`, masked irq and MIE, returning {take, int_or_exc, cause[3:0]}.

Test Plan:
- Illegal + ecall both set, `pc_in`=32'h100:
  - TRAP cycle: cause=2, int_or_exc=0, mepc=32'h100, `pc_sel_out`=01.
  - Next DRAIN.
  - MIE 1→0, MPIE=1.
- MIE=1, `irq_en_in`=3'b111, `irq_pend_in`=3'b111: cause=11, int_or_exc=1. Repeat with MIE=0: no trap, `stall_out`=0.
- Trap then mret: after mret, `pc_sel_out`=10 for 1 cycle, MIE restored to 1, MPIE=1.
- `mret_in` with `exc_req_in`=6'b000100 (ebreak): trap taken, cause=3, no RET state.
- CSR write `MSTATUS` with `data_wr_in`=32'h8 during DRAIN is ignored. The same write in IDLE sets MIE=1.
- Reset pulse (`rst_n_in`=0) asserted mid-TRAP: all outputs 0 immediately, no `mepc_wr_en_out` afterward. With `TRAP_COUNT_EN`, 3 traps give `trap_cnt_out`=3.
